// File: rtl/spi_txn_ctrl.sv
// -----------------------------------------------------------------------------
// spi_txn_ctrl
//   SPI master transaction controller (mode 0). It arbitrates between a host
//   write request and a host read request. Each accepted request goes out as
//   one frame {RW, ADDR, DATA}, MSB first, on spi_mosi. Bits are captured from
//   spi_miso. For read frames, the DATA field on MOSI is driven as zeros, and
//   the last DATA_W captured bits are returned on rd_data.
//
// Ports
//   m_clk, n_reset      system clock and synchronous active-low reset
//   wr_req, rd_req      level requests, each held until its ack
//   req_addr, wr_data   frame contents, sampled on the ack cycle
//   wr_ack, rd_ack      1-cycle accept pulses
//   busy                frame in progress (cycle after ack through done cycle)
//   done, rd_valid      frame-complete pulse; rd_valid only for reads
//   rd_data             last read data, held until the next read completes
//   spi_sclk/cs_n/mosi  SPI outputs (sclk idles low, cs_n idles high)
//   spi_miso            SPI serial input
// -----------------------------------------------------------------------------
module spi_txn_ctrl #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 2,
  parameter int RD_FIRST = 0
) (
  input  logic              m_clk,
  input  logic              n_reset,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]         state;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] tx_sr;
  // One spare bit so the shift also works when DATA_W is 1.
  logic [DATA_W:0]    rx_sr;
  logic               is_read;

  logic               pick_wr;
  logic               pick_rd;
  logic               accept;
  logic               div_wrap;

  // Arbitration between the two request lines and the accept window.
  always_comb begin
    pick_wr = 1'b0;
    pick_rd = 1'b0;
    if (wr_req && rd_req) begin
      if (RD_FIRST != 0) begin
        pick_rd = 1'b1;
      end else begin
        pick_wr = 1'b1;
      end
    end else begin
      pick_wr = wr_req;
      pick_rd = rd_req;
    end
    // Accept in IDLE only if an ack is not already out (that cycle is the
    // ack cycle of the current frame). Also accept in DONE, so the next ack
    // lands on the first IDLE cycle.
    accept = (pick_wr || pick_rd) &&
             (((state == ST_IDLE) && !wr_ack && !rd_ack) || (state == ST_DONE));
    div_wrap = (div_cnt == DIV_LAST);
  end

  // Frame sequencer, SPI pin drivers and host handshake outputs.
  always_ff @(posedge m_clk) begin
    if (!n_reset) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      is_read  <= 1'b0;
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      spi_sclk <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (wr_ack || rd_ack) begin
            // Cycle after the ack: open the frame with the first bit on MOSI.
            state    <= ST_SHIFT;
            busy     <= 1'b1;
            spi_cs_n <= 1'b0;
            spi_sclk <= 1'b0;
            spi_mosi <= tx_sr[FRAME_W-1];
            div_cnt  <= '0;
            bit_cnt  <= BIT_LAST;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          if (div_wrap) begin
            div_cnt <= '0;
            if (!spi_sclk) begin
              // Rising SCLK: the slave has held MISO stable since the last fall.
              spi_sclk <= 1'b1;
              rx_sr    <= {rx_sr[DATA_W-1:0], spi_miso};
            end else begin
              // Falling SCLK: advance to the next bit, or end the shift phase.
              spi_sclk <= 1'b0;
              if (bit_cnt == '0) begin
                state <= ST_HOLD;
              end else begin
                bit_cnt  <= bit_cnt - BIT_W'(1);
                tx_sr    <= {tx_sr[FRAME_W-2:0], 1'b0};
                spi_mosi <= tx_sr[FRAME_W-2];
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        ST_HOLD: begin
          if (div_wrap) begin
            state    <= ST_DONE;
            div_cnt  <= '0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
            done     <= 1'b1;
            if (is_read) begin
              rd_valid <= 1'b1;
              rd_data  <= rx_sr[DATA_W-1:0];
            end else begin
              rd_valid <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          spi_cs_n <= 1'b1;
          spi_sclk <= 1'b0;
          spi_mosi <= 1'b0;
        end
      endcase

      // Request acceptance. This touches only registers that IDLE and DONE
      // leave alone, so it never conflicts with the case above.
      if (accept) begin
        wr_ack  <= pick_wr;
        rd_ack  <= pick_rd;
        is_read <= pick_rd;
        tx_sr   <= {pick_rd, req_addr, (pick_rd ? {DATA_W{1'b0}} : wr_data)};
      end
    end
  end

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_txn_ctrl
//   Directed bench for spi_txn_ctrl with three instances:
//     u0: ADDR_W=7 DATA_W=8 CLK_DIV=2 RD_FIRST=0
//     u1: ADDR_W=7 DATA_W=8 CLK_DIV=2 RD_FIRST=1
//     u2: ADDR_W=1 DATA_W=1 CLK_DIV=1 RD_FIRST=0
//   A simple SPI slave inside run_frame captures MOSI and drives MISO.
// -----------------------------------------------------------------------------
module tb_spi_txn_ctrl;

  logic       clk;
  logic       n_reset;
  logic [2:0] wr_req, rd_req, wr_ack, rd_ack, busy, done, rd_valid;
  logic [2:0] sclk, cs_n, mosi, miso;
  logic [6:0] addr0, addr1;
  logic [7:0] data0, data1, rd_data0, rd_data1;
  logic [0:0] addr2, data2, rd_data2;

  int total;
  int bad;

  spi_txn_ctrl #(.ADDR_W(7), .DATA_W(8), .CLK_DIV(2), .RD_FIRST(0)) u0 (
    .m_clk(clk), .n_reset(n_reset), .wr_req(wr_req[0]), .rd_req(rd_req[0]),
    .req_addr(addr0), .wr_data(data0), .wr_ack(wr_ack[0]), .rd_ack(rd_ack[0]),
    .busy(busy[0]), .done(done[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data0),
    .spi_sclk(sclk[0]), .spi_cs_n(cs_n[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]));

  spi_txn_ctrl #(.ADDR_W(7), .DATA_W(8), .CLK_DIV(2), .RD_FIRST(1)) u1 (
    .m_clk(clk), .n_reset(n_reset), .wr_req(wr_req[1]), .rd_req(rd_req[1]),
    .req_addr(addr1), .wr_data(data1), .wr_ack(wr_ack[1]), .rd_ack(rd_ack[1]),
    .busy(busy[1]), .done(done[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data1),
    .spi_sclk(sclk[1]), .spi_cs_n(cs_n[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]));

  spi_txn_ctrl #(.ADDR_W(1), .DATA_W(1), .CLK_DIV(1), .RD_FIRST(0)) u2 (
    .m_clk(clk), .n_reset(n_reset), .wr_req(wr_req[2]), .rd_req(rd_req[2]),
    .req_addr(addr2), .wr_data(data2), .wr_ack(wr_ack[2]), .rd_ack(rd_ack[2]),
    .busy(busy[2]), .done(done[2]), .rd_valid(rd_valid[2]), .rd_data(rd_data2),
    .spi_sclk(sclk[2]), .spi_cs_n(cs_n[2]), .spi_mosi(mosi[2]), .spi_miso(miso[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise a request just after an edge; return just after the edge that
  // registers the ack (cycle 0).
  task automatic request(input int d, input logic w, input logic r);
    @(posedge clk); #1;
    wr_req[d] = w;
    rd_req[d] = r;
    @(posedge clk); #1;
  endtask

  // Follow one frame from cycle 1 up to its done pulse, acting as SPI slave.
  task automatic run_frame(input int d, input int fw, input logic [15:0] sw,
                           output logic [15:0] cap, output int done_cyc,
                           output logic rv_at_done, output int toggles,
                           output int stray_ack, output int cs_fall_cyc,
                           output int mosi_bad);
    logic ps, pc, pm;
    int   idx;
    cap = '0; done_cyc = -1; rv_at_done = 1'b0; toggles = 0;
    stray_ack = 0; cs_fall_cyc = -1; mosi_bad = 0; idx = 0;
    ps = sclk[d]; pc = cs_n[d]; pm = mosi[d];
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (sclk[d] !== ps) toggles++;
      if (wr_ack[d] || rd_ack[d]) stray_ack++;
      if (done[d]) begin
        done_cyc   = k;
        rv_at_done = rd_valid[d];
        break;
      end
      if (!cs_n[d] && !pc && (mosi[d] !== pm) && !(ps && !sclk[d])) mosi_bad++;
      if (pc && !cs_n[d]) begin
        cs_fall_cyc = k;
        idx = 0;
        miso[d] = sw[fw-1];
      end else if (!ps && sclk[d]) begin
        cap = {cap[14:0], mosi[d]};
        idx++;
      end else if (ps && !sclk[d]) begin
        if (idx < fw) miso[d] = sw[fw-1-idx];
      end
      ps = sclk[d]; pc = cs_n[d]; pm = mosi[d];
    end
    miso[d] = 1'b0;
  endtask

  // Run a frame and check its shape, length and done/rd_valid flags.
  task automatic do_frame(input int d, input int fw, input logic [15:0] sw,
                          input logic [15:0] exp_mosi, input int exp_done,
                          input logic exp_rv, input string tag);
    logic [15:0] cap;
    int done_cyc, toggles, stray, csf, mbad;
    logic rv;
    run_frame(d, fw, sw, cap, done_cyc, rv, toggles, stray, csf, mbad);
    chk({tag, "_mosi"},      32'(cap), 32'(exp_mosi));
    chk({tag, "_done_cyc"},  32'(done_cyc), 32'(exp_done));
    chk({tag, "_rd_valid"},  32'(rv), 32'(exp_rv));
    chk({tag, "_toggles"},   32'(toggles), 32'(2 * fw));
    chk({tag, "_stray_ack"}, 32'(stray), 32'd0);
    chk({tag, "_cs_fall"},   32'(csf), 32'd1);
    chk({tag, "_mosi_edge"}, 32'(mbad), 32'd0);
    chk({tag, "_cs_done"},   32'(cs_n[d]), 32'd1);
    chk({tag, "_busy_done"}, 32'(busy[d]), 32'd1);
  endtask

  initial begin
    int dcount;
    total = 0; bad = 0;
    n_reset = 1'b0;
    wr_req = '0; rd_req = '0; miso = '0;
    addr0 = '0; data0 = '0; addr1 = '0; data1 = '0; addr2 = '0; data2 = '0;

    // Power-on reset: every instance idles.
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_cs_n", 32'(cs_n[d]), 32'd1);
      chk("rst_sclk", 32'(sclk[d]), 32'd0);
      chk("rst_mosi", 32'(mosi[d]), 32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_acks", 32'({wr_ack[d], rd_ack[d], done[d], rd_valid[d]}), 32'd0);
    end
    n_reset = 1'b1;

    // Reset mid-frame: a read of 7'h7F keeps MOSI high early in the frame.
    addr0 = 7'h7F;
    request(0, 1'b0, 1'b1);
    chk("midrst_rd_ack", 32'(rd_ack[0]), 32'd1);
    rd_req[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_pre_cs", 32'(cs_n[0]), 32'd0);
    chk("midrst_pre_mosi", 32'(mosi[0]), 32'd1);
    n_reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_cs_n", 32'(cs_n[0]), 32'd1);
    chk("midrst_sclk", 32'(sclk[0]), 32'd0);
    chk("midrst_mosi", 32'(mosi[0]), 32'd0);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_done", 32'(done[0]), 32'd0);
    n_reset = 1'b1;
    dcount = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (done[0] || rd_valid[0] || !cs_n[0]) dcount++;
    end
    chk("midrst_no_done", 32'(dcount), 32'd0);
    chk("midrst_rd_data", 32'(rd_data0), 32'd0);

    // Write 7'h2D / 8'hA5.
    addr0 = 7'h2D; data0 = 8'hA5;
    request(0, 1'b1, 1'b0);
    chk("wr_ack", 32'(wr_ack[0]), 32'd1);
    chk("wr_ack_busy", 32'(busy[0]), 32'd0);
    chk("wr_ack_cs", 32'(cs_n[0]), 32'd1);
    wr_req[0] = 1'b0;
    do_frame(0, 16, 16'hFFFF, 16'h2DA5, 67, 1'b0, "wr");
    chk("wr_rd_data_kept", 32'(rd_data0), 32'd0);
    @(posedge clk); #1;
    chk("wr_idle_busy", 32'(busy[0]), 32'd0);

    // Read 7'h2D, slave returns 8'h5A in the data phase.
    request(0, 1'b0, 1'b1);
    chk("rd_ack", 32'(rd_ack[0]), 32'd1);
    rd_req[0] = 1'b0;
    do_frame(0, 16, 16'hC35A, 16'hAD00, 67, 1'b1, "rd");
    chk("rd_data", 32'(rd_data0), 32'h5A);

    // Simultaneous requests, write wins; read waits and follows back-to-back.
    addr0 = 7'h11; data0 = 8'h3C;
    request(0, 1'b1, 1'b1);
    chk("both0_wr_ack", 32'(wr_ack[0]), 32'd1);
    chk("both0_rd_ack", 32'(rd_ack[0]), 32'd0);
    wr_req[0] = 1'b0;
    do_frame(0, 16, 16'h0000, 16'h113C, 67, 1'b0, "both0_wr");
    chk("both0_rd_kept", 32'(rd_data0), 32'h5A);
    @(posedge clk); #1;
    chk("both0_rd_ack68", 32'(rd_ack[0]), 32'd1);
    chk("both0_cs68", 32'(cs_n[0]), 32'd1);
    rd_req[0] = 1'b0;
    do_frame(0, 16, 16'hFF96, 16'h9100, 67, 1'b1, "both0_rd");
    chk("both0_rd_data", 32'(rd_data0), 32'h96);

    // Simultaneous requests with read priority.
    addr1 = 7'h40; data1 = 8'h01;
    request(1, 1'b1, 1'b1);
    chk("both1_rd_ack", 32'(rd_ack[1]), 32'd1);
    chk("both1_wr_ack", 32'(wr_ack[1]), 32'd0);
    rd_req[1] = 1'b0;
    do_frame(1, 16, 16'h00C3, 16'hC000, 67, 1'b1, "both1_rd");
    chk("both1_rd_data", 32'(rd_data1), 32'hC3);
    @(posedge clk); #1;
    chk("both1_wr_ack68", 32'(wr_ack[1]), 32'd1);
    chk("both1_cs68", 32'(cs_n[1]), 32'd1);
    wr_req[1] = 1'b0;
    do_frame(1, 16, 16'hFFFF, 16'h4001, 67, 1'b0, "both1_wr");
    chk("both1_rd_kept", 32'(rd_data1), 32'hC3);

    // Minimal 3-bit frames with CLK_DIV=1.
    addr2 = 1'b1; data2 = 1'b0;
    request(2, 1'b1, 1'b0);
    chk("min_wr_ack", 32'(wr_ack[2]), 32'd1);
    wr_req[2] = 1'b0;
    do_frame(2, 3, 16'h0000, 16'h0002, 8, 1'b0, "min_wr");
    addr2 = 1'b0;
    request(2, 1'b0, 1'b1);
    chk("min_rd_ack", 32'(rd_ack[2]), 32'd1);
    rd_req[2] = 1'b0;
    do_frame(2, 3, 16'h0001, 16'h0004, 8, 1'b1, "min_rd");
    chk("min_rd_data", 32'(rd_data2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
